// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the round-key store:
//   - RK_W        : width of one AES round key (always 128 bits)
//   - rk_state_e  : controller states of roundkey_store
//   - nk_of()     : number of round keys for a given AES key length
//                   (128 -> 11, 192 -> 13, 256 -> 15)
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int RK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // nothing stored
    FILL   = 2'd1,  // collecting round keys from the expansion stage
    LOADED = 2'd2,  // full key schedule held, waiting for a playback request
    PLAY   = 2'd3   // presenting keys to the consumer
  } rk_state_e;

  // Round-key count per key length. Anything other than 192/256 is treated
  // as AES-128 so an unexpected parameter still gives a sane schedule size.
  function automatic int nk_of(input int k);
    case (k)
      192:     return 13;
      256:     return 15;
      default: return 11;
    endcase
  endfunction

endpackage

// File: rtl/rk_regfile.sv
// -----------------------------------------------------------------------------
// rk_regfile
//   NK x W register file holding an expanded AES key schedule.
//   One synchronous write port, one registered read port (read data appears
//   the cycle after the address is presented).
//
// Ports
//   clk      in   system clock
//   rst_n    in   async active-low reset; clears the read register only,
//                 the key storage itself is not reset
//   we       in   write enable
//   wr_addr  in   write slot
//   wr_data  in   key to store
//   rd_addr  in   read slot, sampled on the rising edge
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module rk_regfile #(
  parameter int NK = 11,
  parameter int W  = 128,
  parameter int AW = $clog2(NK)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [NK];
  logic [W-1:0] rd_data_q, rd_data_d;

  // Storage has no reset: a flushed or reset schedule is simply overwritten
  // by the next fill before it can be read.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/roundkey_store.sv
// -----------------------------------------------------------------------------
// roundkey_store
//   Captures the NK round keys produced by a key-expansion stage and plays
//   them back, forward or reverse, to a consumer over a valid/ready handshake.
//   The schedule is retained after playback so it can be replayed.
//
// Ports
//   clk         in   system clock
//   reset       in   async active-low reset
//   clr         in   synchronous flush, overrides every other input
//   load_valid  in   roundKey carries the next expanded key
//   roundKey    in   128-bit round key
//   rd_start    in   start a playback (only honoured when the schedule is full)
//   rd_dir      in   playback order, sampled with rd_start (0 = up, 1 = down)
//   rd_ready    in   consumer accepts rk_out
//   rk_valid    out  rk_out is valid
//   rk_out      out  presented round key (0 when rk_valid = 0)
//   rk_last     out  rk_out is the final key of this playback
//   full        out  all NK keys are stored
//   err         out  sticky protocol error (load while full, start when not full)
// -----------------------------------------------------------------------------
module roundkey_store
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load_valid,
  input  logic [RK_W-1:0] roundKey,
  input  logic            rd_start,
  input  logic            rd_dir,
  input  logic            rd_ready,
  output logic            rk_valid,
  output logic [RK_W-1:0] rk_out,
  output logic            rk_last,
  output logic            full,
  output logic            err
);

  localparam int NK = nk_of(K);
  localparam int PW = $clog2(NK);
  localparam logic [PW-1:0] LAST_IDX = PW'(NK - 1);

  rk_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          dir_q, dir_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic          rk_valid_q, rk_valid_d;
  logic          rk_last_q, rk_last_d;

  logic            we;
  logic [PW-1:0]   wr_addr;
  logic            hs;
  logic            at_end;
  logic [PW-1:0]   end_idx_d;
  logic [RK_W-1:0] rd_data;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dir_d    = dir_q;
    full_d   = full_q;
    err_d    = err_q;
    we       = 1'b0;
    wr_addr  = wr_ptr_q;
    hs       = rk_valid_q & rd_ready;
    // Pointer already sits on the final key of the current direction.
    at_end   = dir_q ? (rd_ptr_q == '0) : (rd_ptr_q == LAST_IDX);

    if (clr) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      dir_d    = 1'b0;
      full_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            we       = 1'b1;
            wr_addr  = '0;
            wr_ptr_d = PW'(1);
            state_d  = FILL;
          end
          if (rd_start) err_d = 1'b1;
        end

        FILL: begin
          if (load_valid) begin
            we = 1'b1;
            // The write to the final slot completes the schedule; the write
            // pointer parks there rather than wrapping.
            if (wr_ptr_q == LAST_IDX) begin
              state_d = LOADED;
              full_d  = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
          if (rd_start) err_d = 1'b1;
        end

        LOADED: begin
          if (load_valid) err_d = 1'b1;
          if (rd_start) begin
            state_d  = PLAY;
            dir_d    = rd_dir;
            rd_ptr_d = rd_dir ? LAST_IDX : '0;
          end
        end

        PLAY: begin
          if (load_valid || rd_start) err_d = 1'b1;
          if (hs) begin
            // Accepting the final key ends playback; the pointer stays put.
            if (at_end)     state_d  = LOADED;
            else if (dir_q) rd_ptr_d = rd_ptr_q - 1'b1;
            else            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with the
    // registered read port, which is addressed with rd_ptr_d.
    end_idx_d  = dir_d ? '0 : LAST_IDX;
    rk_valid_d = (state_d == PLAY);
    rk_last_d  = (state_d == PLAY) && (rd_ptr_d == end_idx_d);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dir_q      <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dir_q      <= dir_d;
      full_q     <= full_d;
      err_q      <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Key storage
  // ---------------------------------------------------------------------------
  rk_regfile #(
    .NK (NK),
    .W  (RK_W),
    .AW (PW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (reset),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (roundKey),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

  // Gate the read data so the bus is quiet outside playback (the read
  // register keeps following rd_ptr_d even when nothing is presented).
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_valid_q ? rd_data : '0;
  assign rk_last  = rk_last_q;
  assign full     = full_q;
  assign err      = err_q;

endmodule

// File: doc/roundkey_store.md
ROUNDKEY_STORE -- requirements
Module: roundkey_store

Interface
REQ-001 SHALL have parameter K, default 128: key length; legal values 128/192/256; NK = 11/13/15 round keys.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port clr  input  1  synchronous flush; discards all stored keys.
REQ-005 SHALL have port load_valid  input  1  roundKey carries a new expanded round key this cycle.
REQ-006 SHALL have port roundKey  input  128  round key from the expansion stage.
REQ-007 SHALL have port rd_start  input  1  single-cycle request to begin playback.
REQ-008 SHALL have port rd_dir  input  1  playback order, sampled with rd_start; 0 = index 0..NK-1, 1 = NK-1..0.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts rk_out.
REQ-010 SHALL have port rk_valid  output  1  rk_out holds a valid key.
REQ-011 SHALL have port rk_out  output  128  round key being presented.
REQ-012 SHALL have port rk_last  output  1  rk_out is the final key of the current playback.
REQ-013 SHALL have port full  output  1  all NK keys are stored.
REQ-014 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, LOADED, PLAY.
REQ-016 IDLE: load_valid writes slot 0; wr_ptr becomes 1; next state FILL.
REQ-017 FILL: each load_valid writes slot wr_ptr and increments it; the write to slot NK-1 moves to LOADED and sets full the next cycle.
REQ-018 FILL SHALL tolerate gaps: cycles with load_valid=0 change no state.
REQ-019 LOADED: rd_start moves to PLAY, rd_ptr = 0 (rd_dir=0) or NK-1 (rd_dir=1); rk_valid rises the following cycle, giving 1-cycle latency.
REQ-020 PLAY: rk_out/rk_last SHALL stay stable while rk_valid=1 and rd_ready=0.
REQ-021 PLAY: each rk_valid&rd_ready handshake SHALL advance rd_ptr by +1 (dir 0) or -1 (dir 1); the next key appears the next cycle, with no bubble while rd_ready stays 1.
REQ-022 rk_last SHALL be 1 exactly when rd_ptr is NK-1 (dir 0) or 0 (dir 1).
REQ-023 The handshake on rk_last SHALL return the FSM to LOADED, drop rk_valid the next cycle, and retain the keys so playback can be repeated.
REQ-024 load_valid in LOADED or PLAY SHALL set err, and the write SHALL be ignored.
REQ-025 rd_start outside LOADED SHALL set err and be ignored; rd_start in LOADED with load_valid high SHALL start playback and set err.
REQ-026 clr SHALL return to IDLE, zero wr_ptr/rd_ptr/full/rk_valid/rk_last/err, and override every simultaneous input.
REQ-027 Pointers SHALL be ceil(log2(NK)) bits and never wrap past 0 or NK-1.
REQ-028 rk_out SHALL be 0 whenever rk_valid=0.

Reset
REQ-029 reset=0 SHALL immediately force IDLE and all outputs (rk_valid, rk_out, rk_last, full, err) and pointers to 0; key storage need not be cleared.
REQ-030 A reset during FILL or PLAY SHALL abandon the operation; after release the block accepts a fresh fill from slot 0.

Structure
REQ-031 aes_pkg SHALL hold the state enum and a function that maps K to NK; the block SHALL take NK from that function.
REQ-032 Storage SHALL be one sub-module, rk_regfile: NK x 128 registers with 1 write port and 1 registered read port.

Verification
REQ-033 K=128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c; fill 11 keys, rd_dir=0, rd_ready=1 -> rk_out = 2b7e1516... first and d014f9a8c9ee2589e13f0cc8b6630ca6 on the 11th key with rk_last=1; 11 consecutive valid cycles.
REQ-034 Same fill with rd_dir=1 -> d014f9a8... first, 2b7e1516... last; a second rd_start replays identical data.
REQ-035 K=256, 15 keys with load_valid gaps, random rd_ready -> 15 keys in order; each key is held stable while stalled; full=1 after the 15th write.
REQ-036 A 12th load_valid, K=128 -> err=1; stored data is unchanged on replay.
REQ-037 reset=0 asserted mid-PLAY at key 5 -> rk_valid=0 in the same cycle; after release full=0 and a new fill succeeds.
REQ-038 clr together with rd_start in LOADED -> IDLE, rk_valid stays 0, err=0.
